// File: rtl/l2_arbiter.sv
// Two-client L2 port arbiter: merges L1 I-side and D-side line traffic, one transaction at a time.
// Optional macro L2_ARBITER_RR_EN replaces fixed D-over-I priority with round-robin on ties.
module l2_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_d_req;

  assign w_d_req = d_read | d_write;

  // Read data fans out to both clients; only the granted client's resp qualifies it.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef L2_ARBITER_RR_EN
  // Last granted client: 0 = I side, 1 = D side.
  logic r_last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (r_state == IDLE && w_next == SERVE_D) begin
      r_last_grant <= 1'b1;
    end else if (r_state == IDLE && w_next == SERVE_I) begin
      r_last_grant <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_next     = r_state;
    l2_address = '0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef L2_ARBITER_RR_EN
        if (w_d_req && (!i_read || !r_last_grant)) begin
          w_next = SERVE_D;
        end else if (i_read) begin
          w_next = SERVE_I;
        end
`else
        if (w_d_req) begin
          w_next = SERVE_D;
        end else if (i_read) begin
          w_next = SERVE_I;
        end
`endif
      end
      SERVE_I: begin
        l2_address = i_address;
        l2_read    = 1'b1;
        if (l2_resp) begin
          i_resp = 1'b1;
          w_next = IDLE;
        end
      end
      SERVE_D: begin
        // A combined read+write request is treated as a writeback.
        l2_address = d_address;
        l2_write   = d_write;
        l2_read    = d_read & ~d_write;
        l2_wdata   = d_wdata;
        if (l2_resp) begin
          d_resp = 1'b1;
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
